// File: rtl/sub_rr_arbiter.sv
// sub_rr_arbiter: round-robin arbiter in front of one shared signed subtractor.
// One request is granted per cycle. Its A - B result, its signed-overflow flag
// and its requester index go into a single-entry output register, which is
// drained over a valid/ready response channel.
module sub_rr_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SATURATE = 0,
   parameter int unsigned ID_W     = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_result,
   output logic                   rsp_overflow
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              ovf_q, ovf_d;

   logic              can_accept;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [WIDTH-1:0]  op_a, op_b;
   logic [WIDTH-1:0]  wrapped;
   logic [WIDTH-1:0]  sat_val;
   logic [WIDTH-1:0]  result;
   logic              ovf;

   // The stage can take a new result when it is empty, or when it is draining
   // this cycle. Holding reset keeps every grant off.
   assign can_accept = rst_n && ((state_q == EMPTY) || rsp_ready);

   // Round-robin scan. Start at rr_q, go upward and wrap to 0. The first valid
   // requester found is the grant.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      if (can_accept) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_q) + i) % N_REQ;
            if (!gnt_found && req_valid[idx]) begin
               gnt_found = 1'b1;
               gnt_idx   = idx[ID_W-1:0];
            end
         end
      end
   end

   // Drive a one-hot accept toward the granted requester.
   always_comb begin
      req_ready = '0;
      if (gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Shared subtractor on the granted operands. The low WIDTH bits of the
   // (WIDTH+1)-bit difference match the WIDTH-bit modular difference. Overflow
   // is derived from sign bits, so B = most-negative needs no special case.
   always_comb begin
      op_a    = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
      op_b    = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
      wrapped = op_a - op_b;
      ovf     = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (wrapped[WIDTH-1] != op_a[WIDTH-1]);
      sat_val = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      result  = ((SATURATE != 0) && ovf) ? sat_val : wrapped;
   end

   // Next-state logic for the output stage and the round-robin pointer.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      if (gnt_found) begin
         state_d = FULL;
         rr_d    = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         id_d    = gnt_idx;
         res_d   = result;
         ovf_d   = ovf;
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d = EMPTY;
      end
   end

   // State registers. Asynchronous reset drops any pending response at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         rr_q    <= '0;
         id_q    <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rsp_valid    = (state_q == FULL);
   assign rsp_id       = id_q;
   assign rsp_result   = res_q;
   assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// Testbench for sub_rr_arbiter. Two DUTs, one wrapping and one saturating,
// share all inputs. Both are checked against a behavioural model of the
// arbitration and arithmetic rules.
module tb_sub_rr_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic           rsp_ready = 1'b0;

   logic [N-1:0]   rdy0, rdy1;
   logic           v0, v1;
   logic [IDW-1:0] id0, id1;
   logic [W-1:0]   r0, r1;
   logic           o0, o1;

   always #5 clk = ~clk;

   sub_rr_arbiter #(.N_REQ(N), .WIDTH(W), .SATURATE(0), .ID_W(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
      .req_a(req_a), .req_b(req_b), .rsp_valid(v0), .rsp_ready(rsp_ready),
      .rsp_id(id0), .rsp_result(r0), .rsp_overflow(o0));

   sub_rr_arbiter #(.N_REQ(N), .WIDTH(W), .SATURATE(1), .ID_W(IDW)) dut_s (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
      .req_a(req_a), .req_b(req_b), .rsp_valid(v1), .rsp_ready(rsp_ready),
      .rsp_id(id1), .rsp_result(r1), .rsp_overflow(o1));

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         m_ptr;
   bit         m_full;
   int         m_id;
   logic [W-1:0] m_wr, m_sat;
   bit         m_ovf;

   // Pending-request bookkeeping for the random test
   bit pending [N];

   // Model reset
   task automatic model_reset();
      m_ptr = 0; m_full = 0; m_id = 0; m_wr = '0; m_sat = '0; m_ovf = 0;
   endtask

   // Grant winner, or -1 when the stage cannot accept.
   function automatic int ref_grant();
      int idx;
      if (m_full && !rsp_ready) return -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (req_valid[idx] === 1'b1) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = ref_grant();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // Signed subtraction done in integer arithmetic
   function automatic void ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] wr, output logic [W-1:0] sat,
                                    output bit ov);
      int d;
      d   = int'($signed(a)) - int'($signed(b));
      ov  = (d > 127) || (d < -128);
      wr  = d[W-1:0];
      sat = ov ? ((d > 0) ? 8'h7f : 8'h80) : wr;
   endfunction

   // Advance one clock. Update the model with the same inputs the DUT sees.
   task automatic tick();
      int g;
      g = ref_grant();
      @(posedge clk);
      if (g >= 0) begin
         ref_calc(req_a[g*W +: W], req_b[g*W +: W], m_wr, m_sat, m_ovf);
         m_id   = g;
         m_full = 1;
         m_ptr  = (g + 1) % N;
      end else if (m_full && rsp_ready) begin
         m_full = 0;
      end
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 8'h80;
         1: return 8'h7f;
         2: return 8'hff;
         3: return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b want 0", v0, v1); end
      checks++; if (id0 !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", id0); end
      checks++; if (r0 !== '0 || r1 !== '0) begin errors++; $display("FAIL reset_result: got %0h/%0h want 0", r0, r1); end
      checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o0); end
      checks++; if (rdy0 !== '0 || rdy1 !== '0) begin errors++; $display("FAIL reset_ready: got %b/%b want 0000", rdy0, rdy1); end
      req_valid = '0;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      req_valid = 4'b0001;
      req_a[0 +: W] = 8'd5;
      req_b[0 +: W] = 8'd3;
      rsp_ready = 1'b1;
      #1;
      checks++; if (rdy0 !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b want 0001", rdy0); end
      tick();
      req_valid = '0;
      checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", v0); end
      checks++; if (r0 !== 8'd2) begin errors++; $display("FAIL basic_result: got %0d want 2", r0); end
      checks++; if (id0 !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", id0); end
      checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", o0); end
      tick();
      checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", v0); end
   endtask

   task automatic test_arith();
      int unsigned t_req [7] = '{0, 1, 2, 2, 3, 0, 1};
      logic [W-1:0] t_a  [7] = '{8'h05, 8'h00, 8'h80, 8'hff, 8'h7f, 8'h80, 8'h80};
      logic [W-1:0] t_b  [7] = '{8'h03, 8'h80, 8'h01, 8'hff, 8'hff, 8'h80, 8'h7f};
      logic [W-1:0] t_wr [7] = '{8'h02, 8'h80, 8'h7f, 8'h00, 8'h80, 8'h00, 8'h01};
      logic [W-1:0] t_sat[7] = '{8'h02, 8'h7f, 8'h80, 8'h00, 8'h7f, 8'h00, 8'h80};
      bit           t_ov [7] = '{0, 1, 1, 0, 1, 0, 1};
      logic [N-1:0] onehot;
      rsp_ready = 1'b1;
      for (int t = 0; t < 7; t++) begin
         onehot = '0;
         onehot[t_req[t]] = 1'b1;
         req_valid = onehot;
         req_a[t_req[t]*W +: W] = t_a[t];
         req_b[t_req[t]*W +: W] = t_b[t];
         #1;
         checks++; if (rdy0 !== onehot) begin errors++; $display("FAIL arith_ready[%0d]: got %b want %b", t, rdy0, onehot); end
         tick();
         req_valid = '0;
         checks++; if (r0 !== t_wr[t]) begin errors++; $display("FAIL arith_wrap[%0d]: got %0h want %0h", t, r0, t_wr[t]); end
         checks++; if (r1 !== t_sat[t]) begin errors++; $display("FAIL arith_sat[%0d]: got %0h want %0h", t, r1, t_sat[t]); end
         checks++; if (o0 !== t_ov[t] || o1 !== t_ov[t]) begin errors++; $display("FAIL arith_ovf[%0d]: got %b/%b want %b", t, o0, o1, t_ov[t]); end
         checks++; if (id0 !== IDW'(t_req[t]) || id1 !== IDW'(t_req[t])) begin errors++; $display("FAIL arith_id[%0d]: got %0d/%0d want %0d", t, id0, id1, t_req[t]); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp;
      int first;
      first = m_ptr;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = rnd_op();
         req_b[i*W +: W] = rnd_op();
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         exp = exp_ready();
         checks++; if (rdy0 !== exp || rdy1 !== exp) begin errors++; $display("FAIL b2b_ready[%0d]: got %b/%b want %b", k, rdy0, rdy1, exp); end
         tick();
         checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, v0); end
         checks++; if (id0 !== IDW'((first + k) % N)) begin errors++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, id0, (first + k) % N); end
         checks++; if (r0 !== m_wr || r1 !== m_sat || o0 !== m_ovf) begin errors++; $display("FAIL b2b_data[%0d]: got %0h/%0h/%b want %0h/%0h/%b", k, r0, r1, o0, m_wr, m_sat, m_ovf); end
         req_a[m_id*W +: W] = rnd_op();
         req_b[m_id*W +: W] = rnd_op();
      end
   endtask

   task automatic test_stall();
      logic [N-1:0] exp;
      req_valid = '1;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (rdy0 !== '0 || rdy1 !== '0) begin errors++; $display("FAIL stall_ready[%0d]: got %b/%b want 0000", k, rdy0, rdy1); end
         tick();
         checks++; if (v0 !== 1'b1 || id0 !== IDW'(m_id) || r0 !== m_wr || r1 !== m_sat) begin
            errors++; $display("FAIL stall_hold[%0d]: got v=%b id=%0d r=%0h/%0h want v=1 id=%0d r=%0h/%0h", k, v0, id0, r0, r1, m_id, m_wr, m_sat);
         end
      end
      rsp_ready = 1'b1;
      #1;
      exp = exp_ready();
      checks++; if (rdy0 !== exp || exp == '0) begin errors++; $display("FAIL stall_release_ready: got %b want %b", rdy0, exp); end
      tick();
      checks++; if (v0 !== 1'b1 || id0 !== IDW'(m_id)) begin errors++; $display("FAIL stall_no_bubble: got v=%b id=%0d want v=1 id=%0d", v0, id0, m_id); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] exp;
      for (int i = 0; i < N; i++) pending[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && $urandom_range(0, 1) == 1) begin
               pending[i] = 1;
               req_a[i*W +: W] = rnd_op();
               req_b[i*W +: W] = rnd_op();
            end
            req_valid[i] = pending[i];
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp = exp_ready();
         checks++; if (rdy0 !== exp || rdy1 !== exp) begin errors++; $display("FAIL rand_ready[%0d]: got %b/%b want %b", c, rdy0, rdy1, exp); end
         for (int i = 0; i < N; i++) if (exp[i]) pending[i] = 0;
         tick();
         checks++; if (v0 !== m_full || v1 !== m_full) begin errors++; $display("FAIL rand_valid[%0d]: got %b/%b want %b", c, v0, v1, m_full); end
         if (m_full) begin
            checks++;
            if (id0 !== IDW'(m_id) || id1 !== IDW'(m_id) || r0 !== m_wr || r1 !== m_sat || o0 !== m_ovf || o1 !== m_ovf) begin
               errors++;
               $display("FAIL rand_data[%0d]: got id=%0d r=%0h/%0h o=%b/%b want id=%0d r=%0h/%0h o=%b",
                        c, id0, r0, r1, o0, o1, m_id, m_wr, m_sat, m_ovf);
            end
         end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
   endtask

   task automatic test_async_reset();
      req_valid = 4'b0100;
      req_a[2*W +: W] = 8'd9;
      req_b[2*W +: W] = 8'd4;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (v0 !== 1'b1 || id0 !== 2'd2) begin errors++; $display("FAIL areset_setup: got v=%b id=%0d want v=1 id=2", v0, id0); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL areset_immediate: got %b/%b want 0", v0, v1); end
      checks++; if (rdy0 !== '0) begin errors++; $display("FAIL areset_ready: got %b want 0000", rdy0); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      req_valid = 4'b1100;
      req_a[3*W +: W] = 8'd1;
      req_b[3*W +: W] = 8'd1;
      rsp_ready = 1'b1;
      #1;
      checks++; if (rdy0 !== 4'b0100) begin errors++; $display("FAIL areset_ptr: got %b want 0100", rdy0); end
      tick();
      checks++; if (v0 !== 1'b1 || id0 !== 2'd2 || r0 !== 8'd5) begin errors++; $display("FAIL areset_resp: got v=%b id=%0d r=%0d want v=1 id=2 r=5", v0, id0, r0); end
      req_valid = '0;
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      @(negedge clk);
      test_basic();
      test_arith();
      test_back_to_back();
      test_stall();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/sub_rr_arbiter.md
Name: sub_rr_arbiter

Overview:
Shares one signed WIDTH-bit subtractor datapath between N_REQ requesters.
- A round-robin arbiter grants one request per cycle.
- The granted operands are subtracted (A - B), and the result is registered into a single-entry output stage.
- Result, overflow flag and requester ID are returned over a valid/ready response channel.
- The block sits between the requesting units and the shared arithmetic resource.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, operand/result width in bits, two's complement
SATURATE, 0, 1 = clamp result to +max/-min on overflow; 0 = wrap
ID_W, 2, width of requester index; must equal ceil(log2(N_REQ))

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept; one-hot or zero
req_a  input  N_REQ*WIDTH  minuends; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  subtrahends; same packing
rsp_valid  output  1  response valid
rsp_ready  input  1  downstream accepts response
rsp_id  output  ID_W  index of requester that produced this response
rsp_result  output  WIDTH  signed A - B (wrapped or saturated)
rsp_overflow  output  1  true signed overflow of A - B, reported regardless of SATURATE

Behaviour:
Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, rr pointer=0, req_ready=0.

Output stage states:
- EMPTY: rsp_valid=0.
- FULL: rsp_valid=1.
- can_accept = EMPTY, or (FULL && rsp_ready).

Arbitration (combinational):
- When can_accept, scan req_valid starting at the rr pointer, ascending with wrap to 0.
- The first asserted index g is granted; req_ready[g]=1, all others 0.
- If can_accept=0 or no req_valid is set, req_ready is all zero.
- A handshake occurs on requester g when req_valid[g] && req_ready[g].

On handshake (rising edge):
- rsp_result, rsp_overflow and rsp_id=g load.
- State becomes/stays FULL.
- rr pointer = (g+1) mod N_REQ.
- Latency is one cycle from handshake to rsp_valid.

Other transitions:
- FULL && rsp_ready with no new handshake: next state EMPTY. Data outputs hold their last values.
- FULL && !rsp_ready: all response outputs are held stable, and no requester is granted.
- Simultaneous drain and new grant: back-to-back responses, no bubble. Full throughput is 1 result/cycle.
- The rr pointer changes only on a handshake.

Arithmetic:
- diff = A - B computed in WIDTH+1 bits.
- overflow = (A[msb] != B[msb]) && (wrapped[msb] != A[msb]).
- This correctly flags B = -2^(WIDTH-1). Example: 0 - (-128) overflows. Negating B in WIDTH bits is not allowed.
- SATURATE=1 on overflow: A non-negative gives 2^(WIDTH-1)-1; A negative gives -2^(WIDTH-1).
- Otherwise rsp_result = low WIDTH bits of diff.

Protocol:
- Requesters must hold req_valid and operands stable until accepted.
- Operands are sampled only on the handshake cycle.

Reset mid-operation:
- Any pending response is discarded immediately, with no rsp_valid after reset.
- The rr pointer returns to 0.

Test Plan:
- Reset, then requester 0 sends A=5, B=3 with rsp_ready=1 -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_result=2, rsp_id=0, rsp_overflow=0.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,...; one response per cycle; rsp_id follows the same sequence.
- Requester 1: A=0, B=-128 (WIDTH=8) -> SATURATE=0: result=-128, overflow=1. SATURATE=1: result=127, overflow=1.
- Requester 2: A=-128, B=1 -> SATURATE=0: result=127, overflow=1. SATURATE=1: result=-128. Also check A=-1, B=-1 -> result=0, overflow=0.
- Hold rsp_ready=0 for 3 cycles with requests pending -> rsp_valid, rsp_result and rsp_id stable; req_ready=0. Release -> next grant in the same cycle as the drain, no bubble.
- Assert rst_n=0 asynchronously while rsp_valid=1 -> rsp_valid=0 immediately, without waiting for a clock edge. After release, a grant with requesters 2 and 3 both valid goes to 2, since the pointer was reset to 0.
